br_flow_arb_wrr: RTL and testbench

BR_FLOW_ARB_WRR -- requirements
Module: br_flow_arb_wrr

---
 rtl/br_flow_arb_wrr.sv | 133 +++++++++++++
 tb/tb_br_flow_arb_wrr.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_flow_arb_wrr.sv
// Weighted round-robin flow arbiter with a one-entry registered output.
// The highest-priority flow (ptr) keeps priority for up to config_weight
// consecutive grants before priority moves past it.
module br_flow_arb_wrr #(
  parameter int unsigned NumFlows                       = 2,
  parameter int unsigned Width                          = 1,
  parameter int unsigned WeightWidth                    = 4,
  parameter bit          EnableAssertPushValidStability = 1,
  parameter bit          EnableAssertFinalNotValid      = 1,
  localparam int unsigned FlowIdWidth = (NumFlows > 2) ? $clog2(NumFlows) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumFlows-1:0][WeightWidth-1:0] config_weight,
  output logic [NumFlows-1:0]                 push_ready,
  input  logic [NumFlows-1:0]                 push_valid,
  input  logic [NumFlows-1:0][Width-1:0]      push_data,
  input  logic                                pop_ready,
  output logic                                pop_valid,
  output logic [Width-1:0]                    pop_data,
  output logic [FlowIdWidth-1:0]              pop_flow_id
);

  logic [FlowIdWidth-1:0] ptr;
  logic [WeightWidth-1:0] cnt;

  logic                   can_accept;
  logic                   found;
  logic                   xfer;
  logic [FlowIdWidth:0]   scan_idx;
  logic [FlowIdWidth-1:0] g;
  logic [FlowIdWidth-1:0] g_next;
  logic [WeightWidth-1:0] eff_w;
  logic [WeightWidth:0]   cnt_inc;
  logic [FlowIdWidth-1:0] ptr_next;
  logic [WeightWidth-1:0] cnt_next;

  assign can_accept = !pop_valid || pop_ready;

  // Circular priority scan starting at ptr; first requesting flow wins.
  always_comb begin
    found    = 1'b0;
    g        = ptr;
    scan_idx = '0;
    for (int unsigned k = 0; k < NumFlows; k++) begin
      scan_idx = {1'b0, ptr} + (FlowIdWidth+1)'(k);
      if (scan_idx >= (FlowIdWidth+1)'(NumFlows)) begin
        scan_idx = scan_idx - (FlowIdWidth+1)'(NumFlows);
      end
      if (!found && push_valid[scan_idx[FlowIdWidth-1:0]]) begin
        found = 1'b1;
        g     = scan_idx[FlowIdWidth-1:0];
      end
    end
  end

  assign xfer = found && can_accept && !rst;

  // One-hot grant toward the winner, only when the output slot can take it.
  always_comb begin
    push_ready = '0;
    if (xfer) begin
      push_ready[g] = 1'b1;
    end
  end

  // Burst bookkeeping: a grant outside the current owner restarts the burst
  // at the winner, so the winner's own grant counts as its first.
  always_comb begin
    eff_w    = (config_weight[g] == '0) ? WeightWidth'(1) : config_weight[g];
    cnt_inc  = {1'b0, cnt} + {{WeightWidth{1'b0}}, 1'b1};
    g_next   = (g == FlowIdWidth'(NumFlows - 1)) ? '0 : g + FlowIdWidth'(1);
    ptr_next = ptr;
    cnt_next = cnt;
    if (g == ptr) begin
      if (cnt_inc >= {1'b0, eff_w}) begin
        ptr_next = g_next;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_inc[WeightWidth-1:0];
      end
    end else if (eff_w == WeightWidth'(1)) begin
      ptr_next = g_next;
      cnt_next = '0;
    end else begin
      ptr_next = g;
      cnt_next = WeightWidth'(1);
    end
  end

  // Output register and arbitration state; both advance only on a push transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid   <= 1'b0;
      pop_data    <= '0;
      pop_flow_id <= '0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      if (xfer) begin
        pop_valid   <= 1'b1;
        pop_data    <= push_data[g];
        pop_flow_id <= g;
        ptr         <= ptr_next;
        cnt         <= cnt_next;
      end else if (pop_ready) begin
        pop_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Integration checks on the environment around the arbiter.
  assert property (@(posedge clk) disable iff (rst) NumFlows >= 2);

  if (EnableAssertPushValidStability) begin : g_push_stable
    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
      assert property (@(posedge clk) disable iff (rst)
        push_valid[i] && !push_ready[i] |=> push_valid[i] && $stable(push_data[i]));
    end
  end

  if (EnableAssertFinalNotValid) begin : g_final_not_valid
    final begin
      if (!rst) begin
        assert (push_valid == '0);
        assert (!pop_valid);
      end
    end
  end
`endif

endmodule

// File: tb/tb_br_flow_arb_wrr.sv
// Scoreboard bench for br_flow_arb_wrr: directed weighted-order scenarios
// followed by randomized traffic against a behavioural WRR model.
module tb_br_flow_arb_wrr;

  localparam int unsigned NF  = 5;
  localparam int unsigned W   = 8;
  localparam int unsigned WW  = 4;
  localparam int unsigned IDW = 3;

  logic                  clk;
  logic                  rst;
  logic [NF-1:0][WW-1:0] config_weight;
  logic [NF-1:0]         push_ready;
  logic [NF-1:0]         push_valid;
  logic [NF-1:0][W-1:0]  push_data;
  logic                  pop_ready;
  logic                  pop_valid;
  logic [W-1:0]          pop_data;
  logic [IDW-1:0]        pop_flow_id;

  br_flow_arb_wrr #(
    .NumFlows(NF),
    .Width(W),
    .WeightWidth(WW),
    .EnableAssertPushValidStability(1),
    .EnableAssertFinalNotValid(1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .config_weight(config_weight),
    .push_ready(push_ready),
    .push_valid(push_valid),
    .push_data(push_data),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .pop_data(pop_data),
    .pop_flow_id(pop_flow_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  id;
  } item_t;

  item_t        sb[$];
  int unsigned  vectors     = 0;
  int unsigned  miscompares = 0;

  // Reference model state: owner of the current burst and grants it has used.
  int unsigned  m_ptr;
  int unsigned  m_cnt;

  // Transfer predicted for the upcoming edge.
  int           plan_g;
  logic         plan_rst;
  logic [W-1:0] plan_data;
  int unsigned  plan_w;

  // Directed producers refill after acceptance; random producers go idle.
  bit           keep_valid;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int pick(input logic [NF-1:0] v);
    for (int unsigned k = 0; k < NF; k++) begin
      int unsigned f;
      f = (m_ptr + k) % NF;
      if (v[f]) return int'(f);
    end
    return -1;
  endfunction

  task automatic commit();
    int unsigned eff;
    int unsigned g;
    if (plan_rst) begin
      sb.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else if (plan_g >= 0) begin
      g = int'(plan_g);
      sb.push_back('{data: plan_data, id: g});
      eff = (plan_w == 0) ? 1 : plan_w;
      if (g == m_ptr) begin
        if (m_cnt + 1 >= eff) begin
          m_ptr = (g + 1) % NF;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (eff == 1) begin
        m_ptr = (g + 1) % NF;
        m_cnt = 0;
      end else begin
        m_ptr = g;
        m_cnt = 1;
      end
      if (keep_valid) push_data[g] = W'($urandom);
      else            push_valid[g] = 1'b0;
    end
  endtask

  // One clock with the inputs currently driven; returns 1 time unit after the edge.
  task automatic step();
    logic          can;
    logic [NF-1:0] exp_rdy;
    can      = (sb.size() == 0) || pop_ready;
    plan_rst = rst;
    plan_g   = (rst || !can) ? -1 : pick(push_valid);
    exp_rdy  = '0;
    if (plan_g >= 0) begin
      exp_rdy[plan_g] = 1'b1;
      plan_data       = push_data[plan_g];
      plan_w          = int'(config_weight[plan_g]);
    end
    #1;
    check("push_ready", 32'(push_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    push_valid = '0;
    pop_ready  = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic run_seq(input string name, input int unsigned ids[$]);
    foreach (ids[i]) begin
      step();
      check({name, "_valid"}, 32'(pop_valid), 32'd1);
      check({name, "_id"}, 32'(pop_flow_id), ids[i]);
    end
  endtask

  // Monitor: the output register must match the head of the scoreboard every cycle.
  always @(negedge clk) begin
    if (sb.size() == 0) begin
      check("pop_valid_idle", 32'(pop_valid), 32'd0);
    end else begin
      check("pop_valid", 32'(pop_valid), 32'd1);
      check("pop_data", 32'(pop_data), 32'(sb[0].data));
      check("pop_flow_id", 32'(pop_flow_id), sb[0].id);
      if (pop_ready) void'(sb.pop_front());
    end
  end

  initial begin
    int unsigned seq[$];

    rst           = 1'b1;
    push_valid    = '0;
    push_data     = '0;
    pop_ready     = 1'b1;
    config_weight = '0;
    keep_valid    = 1'b1;
    m_ptr         = 0;
    m_cnt         = 0;
    plan_g        = -1;
    plan_rst      = 1'b1;
    plan_data     = '0;
    plan_w        = 0;

    repeat (2) step();
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_pop_flow_id", 32'(pop_flow_id), 32'd0);
    rst = 1'b0;

    // Weighted order, all three low flows requesting.
    config_weight    = '0;
    config_weight[0] = WW'(1);
    config_weight[1] = WW'(2);
    config_weight[2] = WW'(3);
    for (int unsigned f = 0; f < 3; f++) push_data[f] = W'($urandom);
    push_valid = 5'b00111;
    seq = '{0, 1, 1, 2, 2, 2, 0, 1, 1};
    run_seq("wrr_order", seq);

    // Backpressure holds 0xA5, then grants resume in weighted order.
    do_reset();
    push_data[0] = 8'hA5;
    push_valid   = 5'b00001;
    step();
    check("a5_loaded", 32'(pop_data), 32'hA5);
    push_data[1] = W'($urandom);
    push_data[2] = W'($urandom);
    push_valid   = 5'b00111;
    pop_ready    = 1'b0;
    repeat (5) begin
      step();
      check("hold_valid", 32'(pop_valid), 32'd1);
      check("hold_data", 32'(pop_data), 32'hA5);
      check("hold_id", 32'(pop_flow_id), 32'd0);
    end
    pop_ready = 1'b1;
    seq = '{1, 1, 2, 2, 2, 0};
    run_seq("after_hold", seq);

    // Lone flow 1 opens a weight-3 burst that a late flow 0 cannot break.
    do_reset();
    config_weight[0] = WW'(1);
    config_weight[1] = WW'(3);
    push_data[1]     = W'($urandom);
    push_valid       = 5'b00010;
    seq = '{1};
    run_seq("late_first", seq);
    push_data[0] = W'($urandom);
    push_valid   = 5'b00011;
    seq = '{1, 1, 0};
    run_seq("late_burst", seq);

    // Zero weights behave as weight one: plain round robin.
    do_reset();
    config_weight = '0;
    for (int unsigned f = 0; f < 3; f++) push_data[f] = W'($urandom);
    push_valid = 5'b00111;
    seq = '{0, 1, 2, 0, 1, 2};
    run_seq("rr_zero_w", seq);

    // Reset in the middle of flow 2's burst.
    do_reset();
    config_weight[0] = WW'(1);
    config_weight[1] = WW'(2);
    config_weight[2] = WW'(3);
    for (int unsigned f = 0; f < 3; f++) push_data[f] = W'($urandom);
    push_valid = 5'b00111;
    seq = '{0, 1, 1, 2};
    run_seq("pre_rst", seq);
    rst = 1'b1;
    step();
    check("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
    rst = 1'b0;
    seq = '{0};
    run_seq("post_rst", seq);

    // Flows 4 and 0 alternate across the pointer wrap.
    do_reset();
    for (int unsigned f = 0; f < NF; f++) config_weight[f] = WW'(1);
    push_data[4] = W'($urandom);
    push_data[0] = W'($urandom);
    push_valid   = 5'b10000;
    seq = '{4};
    run_seq("wrap_first", seq);
    push_valid = 5'b10001;
    seq = '{0, 4, 0, 4};
    run_seq("wrap_alt", seq);

    // Randomized traffic, weight changes and occasional resets.
    do_reset();
    keep_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int unsigned f = 0; f < NF; f++) begin
        if (!push_valid[f] && $urandom_range(0, 99) < 45) begin
          push_valid[f] = 1'b1;
          push_data[f]  = W'($urandom);
        end
      end
      if ($urandom_range(0, 31) == 0) begin
        config_weight[$urandom_range(0, NF - 1)] = WW'($urandom_range(0, 5));
      end
      pop_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    // Drain every pending request and the output register.
    pop_ready = 1'b1;
    for (int n = 0; n < 60 && push_valid != '0; n++) step();
    check("drain_push_valid", 32'(push_valid), 32'd0);
    repeat (3) step();
    check("drain_pop_valid", 32'(pop_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
